// File: rtl/debounce_multi.sv
// Multi-channel debouncer: per-channel synchroniser, strobed history, hysteresis decision.
// Define DEBOUNCE_MULTI_EDGE_EN to build the registered rise/fall pulse outputs.
module debounce_multi #(
   parameter int CHANNELS    = 6,
   parameter int HIST_LEN    = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                sample_en,
   input  logic [CHANNELS-1:0] button,
   output logic [CHANNELS-1:0] debounced,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall
);

   logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
   logic [CHANNELS-1:0][HIST_LEN-1:0]    hist_q;
   logic [CHANNELS-1:0][HIST_LEN-1:0]    hist_d;
   logic [CHANNELS-1:0]                  deb_q;
   logic [CHANNELS-1:0]                  deb_d;
   logic [CHANNELS-1:0]                  sync_s;

   function automatic logic all_ones(input logic [HIST_LEN-1:0] h);
      return &h;
   endfunction

   function automatic logic all_zeros(input logic [HIST_LEN-1:0] h);
      return ~|h;
   endfunction

   assign sync_s = sync_q[SYNC_STAGES-1];

   // Synchroniser chain, clocked every cycle independent of the strobe.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= button;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
      end
   end

   // Next history and level; the decision looks at the history including this edge's sample.
   always_comb begin
      hist_d = hist_q;
      deb_d  = deb_q;
      for (int c = 0; c < CHANNELS; c++) begin
         if (sample_en) begin
            hist_d[c] = {hist_q[c][HIST_LEN-2:0], sync_s[c]};
            if (all_ones({hist_q[c][HIST_LEN-2:0], sync_s[c]})) begin
               deb_d[c] = 1'b1;
            end else if (all_zeros({hist_q[c][HIST_LEN-2:0], sync_s[c]})) begin
               deb_d[c] = 1'b0;
            end else begin
               deb_d[c] = deb_q[c];
            end
         end else begin
            hist_d[c] = hist_q[c];
            deb_d[c]  = deb_q[c];
         end
      end
   end

   // History and debounced level registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hist_q <= '0;
         deb_q  <= '0;
      end else begin
         hist_q <= hist_d;
         deb_q  <= deb_d;
      end
   end

   assign debounced = deb_q;

`ifdef DEBOUNCE_MULTI_EDGE_EN
   logic [CHANNELS-1:0] rise_q;
   logic [CHANNELS-1:0] fall_q;

   // Pulses land in the same cycle the new level first appears on debounced.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rise_q <= '0;
         fall_q <= '0;
      end else begin
         rise_q <= deb_d & ~deb_q;
         fall_q <= ~deb_d & deb_q;
      end
   end

   assign rise = rise_q;
   assign fall = fall_q;
`else
   assign rise = '0;
   assign fall = '0;
`endif

endmodule
